// File: rtl/q_8_8_pkg.sv
// q_8_8_pkg: shared types for the q_8_8 fixed-point core and its driver.
//   drv_state_t : driver handshake FSM states
//   op_t        : operation class derived from operand A
//   classify_op : maps operand A to its op_t
package q_8_8_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_HOLD
    } drv_state_t;

    typedef enum logic [1:0] {
        OP_CLR = 2'd0,
        OP_DIV = 2'd1,
        OP_MUL = 2'd2
    } op_t;

    // Negative A selects divide, zero A clears, anything else multiplies.
    function automatic op_t classify_op(input logic [15:0] a);
        if (a[15]) begin
            return OP_DIV;
        end else if (a == 16'h0000) begin
            return OP_CLR;
        end else begin
            return OP_MUL;
        end
    endfunction

endpackage

// File: rtl/q_8_8_driver.sv
// q_8_8_driver: initiator for the q_8_8 start/rdy handshake.
//   Accepts Q8.8 operand pairs on a valid/ready stream, issues each to one
//   q_8_8 core, captures C/carry on completion (or aborts after TIMEOUT
//   cycles) and presents the result on a valid/ready stream.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   in_valid/in_ready/in_a/in_b      operand stream (in_ready while idle)
//   out_valid/out_ready              result stream (out_valid while holding)
//   out_c/out_carry/out_op/out_err   result C, carry (MUL only), op class, timeout flag
//   core_start/core_a/core_b         to q_8_8
//   core_rdy/core_c/core_carry       from q_8_8
//   busy                             an operation is in progress
//   txn_count                        error-free results handed off (wraps)
module q_8_8_driver
    import q_8_8_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_c,
    output logic             out_carry,
    output logic [1:0]       out_op,
    output logic             out_err,
    output logic             core_start,
    output logic [15:0]      core_a,
    output logic [15:0]      core_b,
    input  logic             core_rdy,
    input  logic [15:0]      core_c,
    input  logic             core_carry,
    output logic             busy,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    drv_state_t       state_q, state_d;
    logic [15:0]      a_q, b_q;
    op_t              op_q;
    logic [15:0]      out_c_q;
    logic             out_carry_q;
    logic             out_err_q;
    logic [15:0]      wait_cnt_q;
    logic             seen_low_q;
    logic [CNT_W-1:0] txn_count_q;

    logic do_latch, do_done, do_abort, do_handoff, timed_out;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, datapath strobes and state-decoded outputs
    always_comb begin
        state_d    = state_q;
        do_latch   = 1'b0;
        do_done    = 1'b0;
        do_abort   = 1'b0;
        do_handoff = 1'b0;
        timed_out  = (wait_cnt_q == WAIT_LAST);
        in_ready   = (state_q == S_IDLE);
        core_start = (state_q == S_ISSUE);
        out_valid  = (state_q == S_HOLD);
        busy       = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    do_latch = 1'b1;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                // Timeout beats the core accepting start in the same cycle.
                if (timed_out) begin
                    do_abort = 1'b1;
                    state_d  = S_HOLD;
                end else if (core_rdy) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // rdy only signals completion after it has been seen low.
                if (seen_low_q && core_rdy) begin
                    do_done = 1'b1;
                    state_d = S_HOLD;
                end else if (timed_out) begin
                    do_abort = 1'b1;
                    state_d  = S_HOLD;
                end
            end
            S_HOLD: begin
                if (out_ready) begin
                    do_handoff = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand, result and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= OP_CLR;
            out_c_q     <= '0;
            out_carry_q <= 1'b0;
            out_err_q   <= 1'b0;
            wait_cnt_q  <= '0;
            seen_low_q  <= 1'b0;
            txn_count_q <= '0;
        end else begin
            if (do_latch) begin
                a_q        <= in_a;
                b_q        <= in_b;
                op_q       <= classify_op(in_a);
                wait_cnt_q <= '0;
                seen_low_q <= 1'b0;
            end else if (state_q == S_ISSUE || state_q == S_WAIT) begin
                wait_cnt_q <= wait_cnt_q + 16'd1;
                if (state_q == S_WAIT && !core_rdy) begin
                    seen_low_q <= 1'b1;
                end
            end

            if (do_done) begin
                out_c_q     <= core_c;
                // The core leaves a stale carry on non-multiply ops.
                out_carry_q <= (op_q == OP_MUL) ? core_carry : 1'b0;
                out_err_q   <= 1'b0;
            end else if (do_abort) begin
                out_c_q     <= '0;
                out_carry_q <= 1'b0;
                out_err_q   <= 1'b1;
            end

            if (do_handoff && !out_err_q) begin
                txn_count_q <= txn_count_q + 1'b1;
            end
        end
    end

    assign core_a    = a_q;
    assign core_b    = b_q;
    assign out_c     = out_c_q;
    assign out_carry = out_carry_q;
    assign out_op    = op_q;
    assign out_err   = out_err_q;
    assign txn_count = txn_count_q;

endmodule
